// File: rtl/ir_frame_transmitter.sv
// Sends repeated SIRC-style 12-bit frames (LSB first) on the rover IR LED while transmit is held high.
// Define IR_CARRIER_EN to modulate marks with the carrier; otherwise ir_out is the raw mark envelope.
module ir_frame_transmitter #(
  parameter int CARRIER_PERIOD = 675,
  parameter int UNIT_CYCLES    = 16200,
  parameter int FRAME_CYCLES   = 1215000,
  parameter int START_UNITS    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmit,
  input  logic [11:0] move_command,
  output logic        ir_out,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frames_sent
);

  // state | meaning
  // IDLE  | LED off, waiting for transmit
  // START | start mark, START_UNITS units long
  // GAP   | one-unit space ahead of each payload bit
  // MARK  | payload bit mark: 1 unit for a 0, 2 units for a 1
  // WAIT  | space until the frame period expires
  typedef enum logic [2:0] {IDLE, START, GAP, MARK, WAIT} state_t;

  localparam logic [15:0] START_LAST = 16'(START_UNITS * UNIT_CYCLES - 1);
  localparam logic [15:0] ONE_LAST   = 16'(UNIT_CYCLES - 1);
  localparam logic [15:0] TWO_LAST   = 16'(2 * UNIT_CYCLES - 1);
  localparam logic [20:0] FRAME_LAST = 21'(FRAME_CYCLES - 1);

  state_t      state;
  logic [15:0] unit_cnt;
  logic [20:0] frame_cnt;
  logic [3:0]  bit_idx;
  logic [11:0] shift_reg;
  logic        carrier_next;

`ifdef IR_CARRIER_EN
  localparam int PW = (CARRIER_PERIOD > 2) ? $clog2(CARRIER_PERIOD) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CARRIER_PERIOD - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'(CARRIER_PERIOD / 2);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_inc;

  assign phase_inc    = (phase == PHASE_LAST) ? '0 : phase + PW'(1);
  assign carrier_next = (phase_inc < PHASE_HALF);

  // Every mark is preceded by a space, so holding the phase at 0 outside marks starts each mark high.
  always_ff @(posedge clock) begin
    if (reset || !(state == START || state == MARK)) phase <= '0;
    else                                             phase <= phase_inc;
  end
`else
  assign carrier_next = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      unit_cnt    <= '0;
      frame_cnt   <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      ir_out      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frames_sent <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state != IDLE) frame_cnt <= frame_cnt + 21'd1;
      case (state)
        IDLE: begin
          if (transmit) begin
            shift_reg   <= move_command;
            frames_sent <= '0;
            busy        <= 1'b1;
            frame_cnt   <= '0;
            unit_cnt    <= '0;
            ir_out      <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (unit_cnt == START_LAST) begin
            unit_cnt <= '0;
            bit_idx  <= '0;
            ir_out   <= 1'b0;
            state    <= GAP;
          end else begin
            unit_cnt <= unit_cnt + 16'd1;
            ir_out   <= carrier_next;
          end
        end
        GAP: begin
          if (unit_cnt == ONE_LAST) begin
            unit_cnt <= '0;
            ir_out   <= 1'b1;
            state    <= MARK;
          end else begin
            unit_cnt <= unit_cnt + 16'd1;
          end
        end
        MARK: begin
          if (unit_cnt == (shift_reg[0] ? TWO_LAST : ONE_LAST)) begin
            unit_cnt  <= '0;
            ir_out    <= 1'b0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx < 4'd11) begin
              bit_idx <= bit_idx + 4'd1;
              state   <= GAP;
            end else begin
              state <= WAIT;
            end
          end else begin
            unit_cnt <= unit_cnt + 16'd1;
            ir_out   <= carrier_next;
          end
        end
        WAIT: begin
          if (frame_cnt == FRAME_LAST) begin
            frame_done <= 1'b1;
            if (frames_sent != 8'hFF) frames_sent <= frames_sent + 8'd1;
            frame_cnt <= '0;
            unit_cnt  <= '0;
            if (transmit) begin
              shift_reg <= move_command;
              ir_out    <= 1'b1;
              state     <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_frame_transmitter.sv
// Directed bench for ir_frame_transmitter with short timing (unit 10, carrier 4, frame 600 cycles).
// Expected waveforms follow the IR_CARRIER_EN setting of the build.
module tb_ir_frame_transmitter;
  logic        clock = 1'b0;
  logic        reset;
  logic        transmit;
  logic [11:0] move_command;
  logic        ir_out;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frames_sent;

  int checks = 0;
  int errors = 0;

  ir_frame_transmitter #(
    .CARRIER_PERIOD(4),
    .UNIT_CYCLES(10),
    .FRAME_CYCLES(600),
    .START_UNITS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .transmit(transmit),
    .move_command(move_command),
    .ir_out(ir_out),
    .busy(busy),
    .frame_done(frame_done),
    .frames_sent(frames_sent)
  );

  always #5 clock = ~clock;

  function automatic logic carrier(input int k);
`ifdef IR_CARRIER_EN
    return (k % 4) < 2;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples len cycles of ir_out starting at the current negedge; leaves us at the next segment's first sample.
  task automatic seg(input string tag, input logic mark, input int len);
    int   bad_at;
    logic bad_obs, bad_exp, exp;
    bad_at  = -1;
    bad_obs = 1'b0;
    bad_exp = 1'b0;
    for (int k = 0; k < len; k++) begin
      exp = mark & carrier(k);
      if (ir_out !== exp && bad_at < 0) begin
        bad_at  = k;
        bad_obs = ir_out;
        bad_exp = exp;
      end
      @(negedge clock);
    end
    checks++;
    assert (bad_at < 0) else begin
      errors++;
      $error("FAIL %s: ir_out observed %b expected %b at offset %0d of %0d", tag, bad_obs, bad_exp, bad_at, len);
    end
  endtask

  // Called at the first sample of a frame (START entry); returns at the sample 600 cycles later.
  task automatic check_frame(input string tag, input logic [11:0] payload,
                             input logic exp_busy, input logic [7:0] exp_count);
    int used;
    int bad_at;
    used = 40;
    seg({tag, " start"}, 1'b1, 40);
    for (int i = 0; i < 12; i++) begin
      seg($sformatf("%s gap%0d", tag, i), 1'b0, 10);
      seg($sformatf("%s bit%0d", tag, i), 1'b1, payload[i] ? 20 : 10);
      used += 10 + (payload[i] ? 20 : 10);
    end
    bad_at = -1;
    for (int k = used; k < 600; k++) begin
      if ((ir_out !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1) && bad_at < 0) bad_at = k;
      @(negedge clock);
    end
    checks++;
    assert (bad_at < 0) else begin
      errors++;
      $error("FAIL %s wait: observed ir/done/busy %b%b%b expected 001 at cycle %0d",
             tag, ir_out, frame_done, busy, bad_at);
    end
    check({tag, " frame_done"}, 32'(frame_done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'(exp_busy));
    check({tag, " frames_sent"}, 32'(frames_sent), 32'(exp_count));
  endtask

  initial begin
    reset        = 1'b1;
    transmit     = 1'b0;
    move_command = 12'h000;
    repeat (3) @(negedge clock);
    check("reset ir_out", 32'(ir_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset frames_sent", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single-cycle transmit pulse sends exactly one frame
    move_command = 12'h00A;
    transmit     = 1'b1;
    check("A pre ir_out", 32'(ir_out), 32'd0);
    @(negedge clock);
    transmit = 1'b0;
    check("A latency busy", 32'(busy), 32'd1);
    check_frame("A", 12'h00A, 1'b0, 8'd1);
    @(negedge clock);
    check("A done pulse width", 32'(frame_done), 32'd0);
    seg("A idle", 1'b0, 30);
    check("A idle busy", 32'(busy), 32'd0);
    check("A idle frames_sent", 32'(frames_sent), 32'd1);

    // Held transmit: three back-to-back frames, then release during the third
    move_command = 12'hFFF;
    transmit     = 1'b1;
    @(negedge clock);
    check("B cleared frames_sent", 32'(frames_sent), 32'd0);
    check_frame("B1", 12'hFFF, 1'b1, 8'd1);
    check_frame("B2", 12'hFFF, 1'b1, 8'd2);
    transmit = 1'b0;
    check_frame("B3", 12'hFFF, 1'b0, 8'd3);
    seg("B idle", 1'b0, 20);

    // Payload changes while busy only take effect at the next frame latch
    move_command = 12'h001;
    transmit     = 1'b1;
    @(negedge clock);
    move_command = 12'h800;
    check_frame("C1", 12'h001, 1'b1, 8'd1);
    transmit = 1'b0;
    check_frame("C2", 12'h800, 1'b0, 8'd2);
    seg("C idle", 1'b0, 20);

    // Reset during the bit-5 mark of the second frame
    move_command = 12'h020;
    transmit     = 1'b1;
    @(negedge clock);
    check_frame("D1", 12'h020, 1'b1, 8'd1);
    seg("D2 start", 1'b1, 40);
    for (int i = 0; i < 5; i++) begin
      seg($sformatf("D2 gap%0d", i), 1'b0, 10);
      seg($sformatf("D2 bit%0d", i), 1'b1, 10);
    end
    seg("D2 gap5", 1'b0, 10);
    seg("D2 bit5 head", 1'b1, 5);
    reset    = 1'b1;
    transmit = 1'b0;
    @(negedge clock);
    check("D reset ir_out", 32'(ir_out), 32'd0);
    check("D reset busy", 32'(busy), 32'd0);
    check("D reset frames_sent", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    seg("D quiet after reset", 1'b0, 50);
    check("D quiet busy", 32'(busy), 32'd0);
    check("D quiet frame_done", 32'(frame_done), 32'd0);
    transmit = 1'b1;
    @(negedge clock);
    transmit = 1'b0;
    check("D restart ir_out", 32'(ir_out), 32'd1);
    check("D restart busy", 32'(busy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ir_frame_transmitter.md
Name: ir_frame_transmitter

Overview:
- Downstream stage of the main FSM's move dispatch: consumes the 12-bit move command plus the level-high transmit request and drives the rover IR LED.
- While transmit is held high, sends repeated SIRC-style 12-bit frames on a 40 kHz carrier so that dropped bits are covered by repetition.
- A frame is never truncated; when transmit drops, the frame in flight completes and the block returns to idle.

Parameters:
- CARRIER_PERIOD, 675, clock cycles per carrier period (27 MHz / 40 kHz).
- UNIT_CYCLES, 16200, clock cycles per 0.6 ms timing unit.
- FRAME_CYCLES, 1215000, clock cycles from one frame start to the next (45 ms).
- START_UNITS, 4, start mark length in units.

Ports:
- clock  input  1  system clock, 27 MHz
- reset  input  1  synchronous, active-high
- transmit  input  1  level request; frames repeat while high
- move_command  input  12  payload, [7:0] distance, [11:8] angle
- ir_out  output  1  LED drive, carrier-modulated marks
- busy  output  1  high from frame start until return to IDLE
- frame_done  output  1  one-cycle pulse at the end of each frame period
- frames_sent  output  8  count of completed frames since the last transmit rise; saturates at 255

Behaviour:
- Reset values: ir_out=0, busy=0, frame_done=0, frames_sent=0, state=IDLE, all counters 0.
- Reset mid-frame: ir_out=0 on the next edge; no partial frame resumes.
- States: IDLE, START, GAP, MARK, WAIT.
- IDLE:
  - On the first clock edge with transmit=1: latch move_command into shift register, clear frames_sent.
  - Same edge: set busy=1, clear frame and unit counters, move to START.
  - Latency: envelope high on the cycle after transmit is sampled.
- START: mark for START_UNITS*UNIT_CYCLES cycles, then GAP with bit index 0.
- GAP:
  - Space (ir_out=0) for UNIT_CYCLES cycles, then MARK.
  - Mark length is 2 units if the current bit = 1, else 1 unit.
- MARK:
  - Bits are sent LSB first (bit 0 of distance first, bit 11 last).
  - After the mark, if bit index < 11: increment the index and go to GAP. Else go to WAIT.
- WAIT:
  - Space until the frame counter reaches FRAME_CYCLES-1.
  - On that cycle: pulse frame_done, and increment frames_sent (saturating).
  - Then, if transmit=1: relatch move_command, clear counters, go to START. Else go to IDLE and set busy=0 on the same edge.
- Frame counter runs from the START entry cycle through WAIT. The worst-case payload (all ones) is 40 units = 24 ms, which is less than 45 ms, so WAIT is always entered.
- move_command changes while busy have no effect until the next frame latch.
- transmit deasserted mid-frame: the current frame finishes, including WAIT, then the block goes to IDLE.
- transmit pulsed for a single cycle: exactly one frame is sent.
- Carrier:
  - Phase counter counts 0..CARRIER_PERIOD-1 and wraps.
  - Carrier is high while count < CARRIER_PERIOD/2 (integer division, 337).
  - Counter is cleared on every mark entry, so each mark starts on a high half-cycle.
  - During a mark, ir_out = carrier. During a space or IDLE, ir_out = 0.
- Width rules: unit counter is 16 bits; frame counter is 21 bits; mark-length compare uses START_UNITS*UNIT_CYCLES computed at elaboration.

Optional Feature:
- Macro IR_CARRIER_EN.
- Defined: ir_out is carrier-modulated during marks, as above.
- Undefined:
  - The carrier counter is not instantiated.
  - ir_out equals the raw envelope (1 throughout every mark), for an external modulated driver and for logic-analyzer debug.
  - All timing is otherwise identical.

Test Plan:
- Override UNIT_CYCLES=10, CARRIER_PERIOD=4, FRAME_CYCLES=600.
  - Stimulus: transmit=1 for one cycle, move_command=12'h00A.
  - Required: START mark of 40 cycles.
  - Required: bit marks, LSB first, of 10,20,10,20,10,10,10,10,10,10,10,10 cycles, each preceded by a 10-cycle gap.
  - Required: frame_done pulse at cycle 600 after START entry; busy=0 on the next cycle; frames_sent=1.
- Same overrides, transmit held high for 3 frame periods with move_command=12'hFFF:
  - Required: three identical frames with all 20-cycle marks, frame starts exactly 600 cycles apart, frames_sent=3.
- Change move_command from 12'h001 to 12'h800 mid-frame 1:
  - Required: frame 1 payload is 12'h001; frame 2 payload is 12'h800.
- Assert reset during the bit-5 mark:
  - Required: ir_out=0, busy=0, frames_sent=0 on the next edge; state=IDLE; no output until transmit is reasserted.
- With IR_CARRIER_EN defined, CARRIER_PERIOD=4:
  - Required: ir_out toggles 1,1,0,0 within a mark, starting high at each mark entry.
  - Required with the macro undefined: ir_out is a constant 1 across the same mark.
